urng_sched: RTL and testbench

Round-robin scheduler that shares one three-component Tausworthe uniform generator among `N_REQ` requesters (Box-Muller lanes, dither taps, test ports) in the AWGN datapath. Owns the generator state: seed loading with validity correction, warm-up discard after reset or reseed, and per-grant advancement. The stream handed out is deterministic for a given seed and request pattern.

---
 rtl/awgn_pkg.sv | 18 +
 rtl/taus_step.sv | 17 +
 rtl/urng_sched.sv | 116 +++++++++++
 tb/tb_urng_sched.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/awgn_pkg.sv
// awgn_pkg: shared constants, FSM state type and round-robin index helper for the AWGN datapath.
package awgn_pkg;

    localparam logic [31:0] TAUS_S0_INIT  = 32'hE0E0E0E0;
    localparam logic [31:0] TAUS_S1_INIT  = 32'h0D0D0D0D;
    localparam logic [31:0] TAUS_S2_INIT  = 32'hAA00AA00;

    localparam logic [31:0] TAUS_S0_FLOOR = 32'h0000_0002;
    localparam logic [31:0] TAUS_S1_FLOOR = 32'h0000_0008;
    localparam logic [31:0] TAUS_S2_FLOOR = 32'h0000_0010;

    typedef enum logic {WARM, RUN} urng_sched_state_t;

    function automatic int rr_idx(input int p, input int i, input int n);
        return (p + i) % n;
    endfunction

endpackage

// File: rtl/taus_step.sv
// taus_step: one combinational step of the three-component Tausworthe generator plus its output word.
module taus_step (
    input  logic [31:0] i_s0,
    input  logic [31:0] i_s1,
    input  logic [31:0] i_s2,
    output logic [31:0] o_s0,
    output logic [31:0] o_s1,
    output logic [31:0] o_s2,
    output logic [31:0] o_word
);

    assign o_s0   = ((i_s0 & 32'hFFFFFFFE) << 12) ^ (((i_s0 << 13) ^ i_s0) >> 19);
    assign o_s1   = ((i_s1 & 32'hFFFFFFF8) << 4)  ^ (((i_s1 << 2)  ^ i_s1) >> 25);
    assign o_s2   = ((i_s2 & 32'hFFFFFFF0) << 17) ^ (((i_s2 << 3)  ^ i_s2) >> 11);
    assign o_word = i_s0 ^ i_s1 ^ i_s2;

endmodule

// File: rtl/urng_sched.sv
// urng_sched: round-robin scheduler sharing one Tausworthe generator among N_REQ requesters,
// with seed loading, warm-up discard and one generator advance per grant.
module urng_sched
    import awgn_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int WARMUP = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     seed_load,
    input  logic [31:0]              seed_s0,
    input  logic [31:0]              seed_s1,
    input  logic [31:0]              seed_s2,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic                     rand_valid,
    output logic [31:0]              rand_data,
    output logic [$clog2(N_REQ)-1:0] rand_id,
    output logic                     ready
);

    localparam int IW = $clog2(N_REQ);

    urng_sched_state_t r_state;
    logic [7:0]        r_cnt;
    logic [31:0]       r_s0, r_s1, r_s2;
    logic [IW-1:0]     r_ptr;
    logic [N_REQ-1:0]  r_gnt;
    logic              r_valid;
    logic [31:0]       r_data;
    logic [IW-1:0]     r_id;
    logic              r_ready;

    logic [31:0]       w_n0, w_n1, w_n2, w_word;
    logic              w_found;
    logic [IW-1:0]     w_cand, w_win, w_ptr_nxt;

    taus_step u_step (
        .i_s0  (r_s0),
        .i_s1  (r_s1),
        .i_s2  (r_s2),
        .o_s0  (w_n0),
        .o_s1  (w_n1),
        .o_s2  (w_n2),
        .o_word(w_word)
    );

    // Scan from the farthest offset down so the requester closest to r_ptr wins last.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_cand = IW'(rr_idx(int'(r_ptr), i, N_REQ));
            if (req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
        w_ptr_nxt = IW'(rr_idx(int'(w_win), 1, N_REQ));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= WARM;
            r_cnt   <= 8'(WARMUP);
            r_s0    <= TAUS_S0_INIT;
            r_s1    <= TAUS_S1_INIT;
            r_s2    <= TAUS_S2_INIT;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_id    <= '0;
            r_ready <= 1'b0;
        end else begin
            r_gnt   <= '0;
            r_valid <= 1'b0;
            if (seed_load) begin
                r_state <= WARM;
                r_cnt   <= 8'(WARMUP);
                r_s0    <= seed_s0 | TAUS_S0_FLOOR;
                r_s1    <= seed_s1 | TAUS_S1_FLOOR;
                r_s2    <= seed_s2 | TAUS_S2_FLOOR;
                r_ready <= 1'b0;
            end else if (r_state == WARM) begin
                if (r_cnt == 8'd0) begin
                    r_state <= RUN;
                    r_ready <= 1'b1;
                end else begin
                    r_s0  <= w_n0;
                    r_s1  <= w_n1;
                    r_s2  <= w_n2;
                    r_cnt <= r_cnt - 8'd1;
                end
            end else if (w_found) begin
                r_s0    <= w_n0;
                r_s1    <= w_n1;
                r_s2    <= w_n2;
                r_gnt   <= N_REQ'(1) << w_win;
                r_valid <= 1'b1;
                r_data  <= w_word;
                r_id    <= w_win;
                r_ptr   <= w_ptr_nxt;
            end
        end
    end

    assign gnt        = r_gnt;
    assign rand_valid = r_valid;
    assign rand_data  = r_data;
    assign rand_id    = r_id;
    assign ready      = r_ready;

endmodule

// File: tb/tb_urng_sched.sv
// tb_urng_sched: directed bench for urng_sched; one instance with WARMUP=0 and one with WARMUP=3
// share the stimulus, and a software Tausworthe model supplies the expected words.
module tb_urng_sched;

    localparam int N = 4;
    localparam logic [95:0] INIT = {32'hE0E0E0E0, 32'h0D0D0D0D, 32'hAA00AA00};

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        seed_load = 1'b0;
    logic [31:0] seed_s0 = '0, seed_s1 = '0, seed_s2 = '0;
    logic [N-1:0] req = '0;

    logic [N-1:0] gnt0, gnt1;
    logic         val0, val1, rdy0, rdy1;
    logic [31:0]  dat0, dat1;
    logic [1:0]   id0, id1;

    int n_chk = 0;
    int n_err = 0;

    logic [95:0] m0, m1;
    logic [31:0] last;
    int          m_ptr, w;
    int          hits [N];

    urng_sched #(.N_REQ(N), .WARMUP(0)) u0 (
        .clock(clock), .reset(reset), .seed_load(seed_load),
        .seed_s0(seed_s0), .seed_s1(seed_s1), .seed_s2(seed_s2),
        .req(req), .gnt(gnt0), .rand_valid(val0), .rand_data(dat0),
        .rand_id(id0), .ready(rdy0)
    );

    urng_sched #(.N_REQ(N), .WARMUP(3)) u1 (
        .clock(clock), .reset(reset), .seed_load(seed_load),
        .seed_s0(seed_s0), .seed_s1(seed_s1), .seed_s2(seed_s2),
        .req(req), .gnt(gnt1), .rand_valid(val1), .rand_data(dat1),
        .rand_id(id1), .ready(rdy1)
    );

    always #5 clock = ~clock;

    function automatic logic [95:0] tstep(input logic [95:0] s);
        logic [31:0] s0, s1, s2, n0, n1, n2;
        s0 = s[95:64];
        s1 = s[63:32];
        s2 = s[31:0];
        n0 = ((s0 & 32'hFFFFFFFE) << 12) ^ (((s0 << 13) ^ s0) >> 19);
        n1 = ((s1 & 32'hFFFFFFF8) << 4)  ^ (((s1 << 2)  ^ s1) >> 25);
        n2 = ((s2 & 32'hFFFFFFF0) << 17) ^ (((s2 << 3)  ^ s2) >> 11);
        return {n0, n1, n2};
    endfunction

    function automatic logic [31:0] tword(input logic [95:0] s);
        return s[95:64] ^ s[63:32] ^ s[31:0];
    endfunction

    function automatic int rr_win(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        tick;
        tick;
        check("rst_gnt", 32'(gnt0), 0);
        check("rst_valid", 32'(val0), 0);
        check("rst_data", dat0, 0);
        check("rst_id", 32'(id0), 0);
        check("rst_ready", 32'(rdy0), 0);
        check("rst_ready_w3", 32'(rdy1), 0);

        reset = 1'b0;
        req = 4'b0001;
        tick;
        check("warm0_exit_ready", 32'(rdy0), 1);
        check("warm0_no_valid", 32'(val0), 0);
        tick;
        check("first_valid", 32'(val0), 1);
        check("first_data", dat0, 32'h47ED47ED);
        check("first_id", 32'(id0), 0);
        check("first_gnt", 32'(gnt0), 1);
        m0 = tstep(INIT);
        tick;
        check("second_data", dat0, tword(m0));
        check("warm3_ready_low", 32'(rdy1), 0);
        m0 = tstep(m0);
        m1 = tstep(tstep(tstep(INIT)));

        req = 4'b1111;
        m_ptr = 1;
        for (int k = 0; k < 5; k++) begin
            tick;
            check("rr_valid", 32'(val0), 1);
            check("rr_id", 32'(id0), m_ptr);
            check("rr_gnt", 32'(gnt0), 32'(1) << m_ptr);
            check("rr_data", dat0, tword(m0));
            m0 = tstep(m0);
            m_ptr = (m_ptr + 1) % N;
            if (k == 0) begin
                check("warm3_exit_ready", 32'(rdy1), 1);
                check("warm3_no_valid", 32'(val1), 0);
            end
            if (k == 1) begin
                check("warm3_first_valid", 32'(val1), 1);
                check("warm3_first_data", dat1, tword(m1));
                check("warm3_first_id", 32'(id1), 0);
            end
        end

        last = dat0;
        seed_load = 1'b1;
        req = 4'b0100;
        tick;
        seed_load = 1'b0;
        check("sl_no_valid", 32'(val0), 0);
        check("sl_no_gnt", 32'(gnt0), 0);
        check("sl_data_hold", dat0, last);
        check("sl_ready", 32'(rdy0), 0);
        check("sl_ready_w3", 32'(rdy1), 0);
        m0 = {32'h2, 32'h8, 32'h10};
        m1 = tstep(tstep(tstep(m0)));
        for (int j = 0; j < 5; j++) begin
            tick;
            check("sl_ready_w3_seq", 32'(rdy1), (j >= 3) ? 1 : 0);
            if (j == 0) begin
                check("sl_exit_ready", 32'(rdy0), 1);
                check("sl_exit_no_valid", 32'(val0), 0);
                req = 4'b0111;
            end else begin
                w = rr_win(req, m_ptr);
                check("sl_valid", 32'(val0), 1);
                check("sl_id", 32'(id0), w);
                check("sl_data", dat0, tword(m0));
                m0 = tstep(m0);
                m_ptr = (w + 1) % N;
            end
            if (j == 1) check("sl_floor_word", dat0, 32'h0000001A);
            if (j == 4) begin
                check("sl_w3_valid", 32'(val1), 1);
                check("sl_w3_data", dat1, tword(m1));
                check("sl_w3_id", 32'(id1), 0);
            end
        end

        req = 4'b1111;
        reset = 1'b1;
        tick;
        check("rst2_gnt", 32'(gnt0), 0);
        check("rst2_valid", 32'(val0), 0);
        check("rst2_data", dat0, 0);
        check("rst2_id", 32'(id0), 0);
        check("rst2_ready", 32'(rdy0), 0);
        check("rst2_ready_w3", 32'(rdy1), 0);
        tick;
        reset = 1'b0;
        tick;
        check("rst2_no_valid", 32'(val0), 0);
        tick;
        check("rst2_valid1", 32'(val0), 1);
        check("rst2_first_data", dat0, 32'h47ED47ED);
        check("rst2_first_id", 32'(id0), 0);
        m0 = tstep(INIT);
        m_ptr = 1;

        for (int i = 0; i < N; i++) hits[i] = 0;
        for (int i = 0; i < 16; i++) begin
            req = i[0] ? 4'b0101 : 4'b1010;
            tick;
            w = rr_win(req, m_ptr);
            check("tog_gnt", 32'(gnt0), 32'(1) << w);
            check("tog_onehot", 32'($onehot(gnt0)), 1);
            check("tog_active", 32'((gnt0 & req) != 0), 1);
            check("tog_data", dat0, tword(m0));
            m0 = tstep(m0);
            m_ptr = (w + 1) % N;
            hits[w]++;
        end
        for (int i = 0; i < N; i++) check("tog_share", 32'(hits[i]), 4);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
